// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the writeback packer: rounding modes,
// format limits, canonical NaNs and the payload carried between pipeline stages.
package fpu_pkg;

    localparam int FPU_MANT_W = 58;
    localparam int FPU_XEXP_W = 16;

    typedef logic signed [FPU_XEXP_W-1:0] xexp_t;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_ZERO = 2'd1,
        SP_INF  = 2'd2,
        SP_NAN  = 2'd3
    } special_e;

    localparam xexp_t BIAS32 = 16'sd127;
    localparam xexp_t BIAS64 = 16'sd1023;
    localparam xexp_t EMAX32 = 16'sd255;
    localparam xexp_t EMAX64 = 16'sd2047;

    localparam logic [31:0] NAN32     = 32'h7FC0_0000;
    localparam logic [63:0] NAN64     = 64'h7FF8_0000_0000_0000;
    localparam logic [30:0] MAXFIN32  = 31'h7F7F_FFFF;
    localparam logic [62:0] MAXFIN64  = 63'h7FEF_FFFF_FFFF_FFFF;

    // One unit in the last place of the extended mantissa for each format.
    localparam logic [FPU_MANT_W-1:0] ULP64 = 58'h10;
    localparam logic [FPU_MANT_W-1:0] ULP32 = 58'h2_0000_0000;

    // After S2 the sticky field carries the item's inexact status.
    typedef struct packed {
        logic                  sign;
        xexp_t                 exp;
        logic [FPU_MANT_W-1:0] mant;
        logic                  precision;
        rm_e                   rm;
        special_e              special;
        logic                  tiny;
        logic                  sticky;
    } stage_t;

    function automatic rm_e decode_rm(input logic [2:0] raw);
        case (raw)
            3'd1:    return RM_RTZ;
            3'd2:    return RM_RDN;
            3'd3:    return RM_RUP;
            3'd4:    return RM_RMM;
            default: return RM_RNE;
        endcase
    endfunction

endpackage

// File: rtl/fp_encoder_if.sv
// Handshake and data bundle between the FPU datapath (master) and the packer (slave).
interface fp_encoder_if #(
    parameter int EXP_W  = 13,
    parameter int MANT_W = 58
);
    logic              in_valid;
    logic              in_ready;
    logic              is_double_precision;
    logic [2:0]        rm;
    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mant_in;
    logic              is_zero_in;
    logic              is_inf_in;
    logic              is_nan_in;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       fp_out;
    logic              flag_overflow;
    logic              flag_underflow;
    logic              flag_inexact;

    modport master (
        output in_valid, is_double_precision, rm, sign_in, exp_in, mant_in,
               is_zero_in, is_inf_in, is_nan_in, out_ready,
        input  in_ready, out_valid, fp_out, flag_overflow, flag_underflow, flag_inexact
    );

    modport slave (
        input  in_valid, is_double_precision, rm, sign_in, exp_in, mant_in,
               is_zero_in, is_inf_in, is_nan_in, out_ready,
        output in_ready, out_valid, fp_out, flag_overflow, flag_underflow, flag_inexact
    );
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero counter: number of zero bits above the most significant set bit
// of data; an all-zero word returns W.
module fp_lzc #(
    parameter int W  = 57,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count
);
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (data[i]) count = CW'(W - 1 - i);
        end
    end
endmodule

// File: rtl/fp_encoder.sv
// Pipelined FP32/FP64 packer: S1 normalize, S2 round, S3 pack, all stages
// advancing together whenever the output slot is free or being consumed.
module fp_encoder
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 13,
    parameter int MANT_W = 58
) (
    input  logic        clk,
    input  logic        rst,
    fp_encoder_if.slave bus
);
    localparam int LZ_W = $clog2(MANT_W);

    logic              advance;
    logic              s1_valid, s2_valid, s3_valid;
    stage_t            s1_q, s1_d, s2_q, s2_d;
    logic [63:0]       fp_q, fp_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
    logic [EXP_W-1:0]  exp_raw;
    logic [MANT_W-1:0] mant_raw;
    logic [LZ_W-1:0]   lz;

    assign advance            = !s3_valid || bus.out_ready;
    assign bus.in_ready       = advance;
    assign bus.out_valid      = s3_valid;
    assign bus.fp_out         = fp_q;
    assign bus.flag_overflow  = ovf_q;
    assign bus.flag_underflow = unf_q;
    assign bus.flag_inexact   = inx_q;
    assign exp_raw            = bus.exp_in;
    assign mant_raw           = bus.mant_in;

    fp_lzc #(.W(MANT_W - 1), .CW(LZ_W)) u_lzc (
        .data  (mant_raw[MANT_W-2:0]),
        .count (lz)
    );

    xexp_t                 e1, dist1;
    logic [FPU_MANT_W-1:0] m1, mask1;
    logic [6:0]            sh1;
    logic                  st1;

    always_comb begin
        s1_d  = '0;
        e1    = xexp_t'($signed(exp_raw));
        m1    = mant_raw;
        st1   = 1'b0;
        dist1 = '0;
        sh1   = '0;
        mask1 = '0;
        if (m1[FPU_MANT_W-1]) begin
            st1 = m1[0];
            m1  = m1 >> 1;
            e1  = e1 + 16'sd1;
        end else begin
            m1 = m1 << lz;
            e1 = e1 - xexp_t'({{(FPU_XEXP_W-LZ_W){1'b0}}, lz});
        end
        s1_d.tiny = (e1 < 16'sd1);
        // Denormal: align to the exp=1 scale, saturating the shift so huge
        // negative exponents collapse into sticky.
        if (s1_d.tiny) begin
            dist1 = 16'sd1 - e1;
            sh1   = (dist1 >= xexp_t'(FPU_MANT_W)) ? 7'(FPU_MANT_W) : dist1[6:0];
            mask1 = ~({FPU_MANT_W{1'b1}} << sh1);
            st1   = st1 | (|(m1 & mask1));
            m1    = m1 >> sh1;
            e1    = '0;
        end
        if (bus.is_nan_in)                            s1_d.special = SP_NAN;
        else if (bus.is_inf_in)                       s1_d.special = SP_INF;
        else if (bus.is_zero_in || mant_raw == '0)    s1_d.special = SP_ZERO;
        else                                          s1_d.special = SP_NONE;
        s1_d.sign      = bus.sign_in;
        s1_d.exp       = e1;
        s1_d.mant      = m1;
        s1_d.precision = bus.is_double_precision;
        s1_d.rm        = decode_rm(bus.rm);
        s1_d.sticky    = st1;
    end

    logic                  dp2, lsb2, g2, st2, inx2, inc2;
    logic [FPU_MANT_W-1:0] trunc2, m2;
    xexp_t                 e2;

    always_comb begin
        s2_d = s1_q;
        dp2  = s1_q.precision;
        lsb2 = dp2 ? s1_q.mant[4] : s1_q.mant[33];
        g2   = dp2 ? s1_q.mant[3] : s1_q.mant[32];
        st2  = s1_q.sticky | (dp2 ? (|s1_q.mant[2:0]) : (|s1_q.mant[31:0]));
        inx2 = g2 | st2;
        case (s1_q.rm)
            RM_RTZ:  inc2 = 1'b0;
            RM_RDN:  inc2 = s1_q.sign & inx2;
            RM_RUP:  inc2 = !s1_q.sign & inx2;
            RM_RMM:  inc2 = g2;
            default: inc2 = g2 & (st2 | lsb2);
        endcase
        trunc2 = dp2 ? {s1_q.mant[57:4], 4'b0} : {s1_q.mant[57:33], 33'b0};
        m2     = trunc2 + (inc2 ? (dp2 ? ULP64 : ULP32) : '0);
        e2     = s1_q.exp;
        if (m2[57]) begin
            m2 = m2 >> 1;
            e2 = e2 + 16'sd1;
        end else if (e2 == 16'sd0 && m2[56]) begin
            e2 = 16'sd1;
        end
        s2_d.mant   = m2;
        s2_d.exp    = e2;
        s2_d.sticky = inx2;
    end

    logic  dp3, sg3, to_inf3;
    xexp_t e3;

    always_comb begin
        fp_d    = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        inx_d   = 1'b0;
        dp3     = s2_q.precision;
        sg3     = s2_q.sign;
        e3      = s2_q.exp;
        to_inf3 = (s2_q.rm == RM_RNE) || (s2_q.rm == RM_RMM) ||
                  (s2_q.rm == RM_RUP && !sg3) || (s2_q.rm == RM_RDN && sg3);
        case (s2_q.special)
            SP_NAN:  fp_d = dp3 ? NAN64 : {32'h0, NAN32};
            SP_INF:  fp_d = dp3 ? {sg3, 11'h7FF, 52'h0} : {32'h0, sg3, 8'hFF, 23'h0};
            SP_ZERO: fp_d = dp3 ? {sg3, 63'h0} : {32'h0, sg3, 31'h0};
            default: begin
                if (e3 >= (dp3 ? EMAX64 : EMAX32)) begin
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                    if (to_inf3) fp_d = dp3 ? {sg3, 11'h7FF, 52'h0} : {32'h0, sg3, 8'hFF, 23'h0};
                    else         fp_d = dp3 ? {sg3, MAXFIN64} : {32'h0, sg3, MAXFIN32};
                end else begin
                    fp_d  = dp3 ? {sg3, e3[10:0], s2_q.mant[55:4]}
                                : {32'h0, sg3, e3[7:0], s2_q.mant[55:33]};
                    inx_d = s2_q.sticky;
                    unf_d = s2_q.tiny & s2_q.sticky;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
            fp_q     <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else if (advance) begin
            s1_valid <= bus.in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            fp_q     <= fp_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

endmodule

// File: tb/tb_fp_encoder.sv
// Bench for fp_encoder: directed corner cases, backpressure and reset, then
// randomized traffic scored against a value-level rounding reference.
module tb_fp_encoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_encoder_if #(.EXP_W(13), .MANT_W(58)) bus ();
    fp_encoder #(.EXP_W(13), .MANT_W(58)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] fp;
        logic [2:0]  fl;   // {overflow, underflow, inexact}
        int          acc;
        bit          lat;
    } ref_t;

    ref_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          acc_last;
    bit          dir_en = 1'b0;
    logic [63:0] dir_fp;
    logic [2:0]  dir_fl;
    int          n_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Value model: quantise mant*2^(exp-56) onto the ulp grid of its binade
    // (or the denormal grid), round, and let the carry flow into the exponent.
    function automatic ref_t ref_model(input bit dp, input logic [2:0] rm, input bit sg,
                                       input logic [12:0] e13, input logic [57:0] m,
                                       input bit z, input bit inf, input bit nan);
        ref_t         r;
        int           f, emax, e, p, e_norm, e_eff, k, s, rmx;
        logic [127:0] mm, q, enc;
        bit           g, st, inc, tiny, inx, to_inf;
        r.fp = '0; r.fl = '0; r.acc = 0; r.lat = 1'b0;
        f    = dp ? 52 : 23;
        emax = dp ? 2047 : 255;
        if (nan) begin
            r.fp = dp ? 64'h7FF8000000000000 : 64'h7FC00000;
            return r;
        end
        if (inf) begin
            r.fp = dp ? {sg, 11'h7FF, 52'h0} : {32'h0, sg, 8'hFF, 23'h0};
            return r;
        end
        if (z || m == '0) begin
            r.fp = dp ? {sg, 63'h0} : {32'h0, sg, 31'h0};
            return r;
        end
        e = int'($signed(e13));
        p = 57;
        while (p > 0 && !m[p]) p--;
        e_norm = e + p - 56;
        tiny   = (e_norm < 1);
        e_eff  = tiny ? 1 : e_norm;
        k      = e - e_eff - 56 + f;
        mm     = 128'(m);
        g = 1'b0; st = 1'b0;
        if (k >= 0) begin
            q = mm << k;
        end else begin
            s = -k;
            if (s > 100) begin
                q = '0; st = 1'b1;
            end else begin
                q  = mm >> s;
                g  = mm[s-1];
                st = ((mm & ((128'd1 << (s - 1)) - 128'd1)) != '0);
            end
        end
        inx = g | st;
        rmx = (rm > 3'd4) ? 0 : int'(rm);
        case (rmx)
            1:       inc = 1'b0;
            2:       inc = sg & inx;
            3:       inc = !sg & inx;
            4:       inc = g;
            default: inc = g & (st | q[0]);
        endcase
        q   = q + 128'(inc);
        enc = (128'(e_eff - 1) << f) + q;
        if (enc >= (128'(emax) << f)) begin
            to_inf = (rmx == 0) || (rmx == 4) || (rmx == 3 && !sg) || (rmx == 2 && sg);
            if (dp) r.fp = to_inf ? {sg, 63'h7FF0000000000000} : {sg, 63'h7FEFFFFFFFFFFFFF};
            else    r.fp = to_inf ? {32'h0, sg, 31'h7F800000} : {32'h0, sg, 31'h7F7FFFFF};
            r.fl = 3'b101;
        end else begin
            r.fp = dp ? {sg, enc[62:0]} : {32'h0, sg, enc[30:0]};
            r.fl = {1'b0, tiny & inx, inx};
        end
        return r;
    endfunction

    // Observe one cycle just after the falling edge: score an output transfer,
    // log an input transfer, then wait for the next falling edge.
    task automatic tick();
        ref_t r, e;
        #1;
        acc_last = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("stray_out", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("fp_out", bus.fp_out, e.fp);
                check("flags", {61'd0, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact},
                      {61'd0, e.fl});
                if (e.lat) check("latency", 64'(cyc - e.acc), 64'd3);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            acc_last = 1'b1;
            r = ref_model(bus.is_double_precision, bus.rm, bus.sign_in, bus.exp_in,
                          bus.mant_in, bus.is_zero_in, bus.is_inf_in, bus.is_nan_in);
            if (dir_en) begin
                r.fp = dir_fp;
                r.fl = dir_fl;
            end
            r.acc = cyc;
            r.lat = dir_en;
            sb_q.push_back(r);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input bit dp, input logic [2:0] rm, input bit sg, input logic [12:0] e,
                         input logic [57:0] m, input bit z, input bit inf, input bit nan);
        bus.in_valid            = 1'b1;
        bus.is_double_precision = dp;
        bus.rm                  = rm;
        bus.sign_in             = sg;
        bus.exp_in              = e;
        bus.mant_in             = m;
        bus.is_zero_in          = z;
        bus.is_inf_in           = inf;
        bus.is_nan_in           = nan;
    endtask

    task automatic send_dir(input bit dp, input logic [2:0] rm, input bit sg, input logic [12:0] e,
                            input logic [57:0] m, input bit z, input bit inf, input bit nan,
                            input logic [63:0] fp, input logic [2:0] fl);
        drive(dp, rm, sg, e, m, z, inf, nan);
        dir_en = 1'b1;
        dir_fp = fp;
        dir_fl = fl;
        tick();
        check("dir_accept", {63'd0, acc_last}, 64'd1);
        dir_en       = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic rand_drive();
        logic [63:0] r64;
        logic [57:0] m;
        int          p, e, emax;
        bit          dp;
        dp   = 1'($urandom_range(0, 1));
        emax = dp ? 2047 : 255;
        p    = $urandom_range(0, 57);
        r64  = {$urandom, $urandom};
        m    = r64[57:0] & ((58'd1 << p) - 58'd1);
        m[p] = 1'b1;
        if ($urandom_range(0, 3) == 0) m = m & ~((58'd1 << $urandom_range(0, p)) - 58'd1);
        if ($urandom_range(0, 39) == 0) m = '0;
        case ($urandom_range(0, 9))
            0:       e = int'($urandom_range(0, 8191)) - 4096;
            1, 2:    e = int'($urandom_range(0, 70)) - 64;
            3:       e = emax - 3 + int'($urandom_range(0, 4));
            default: e = int'($urandom_range(1, emax - 1));
        endcase
        drive(dp, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 13'(e), m,
              $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 13'd0, 58'd0, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_fp_out", bus.fp_out, 64'd0);
        check("rst_flags", {61'd0, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        send_dir(1, 0, 0, 13'd1023, 58'd1 << 56,                   0, 0, 0, 64'h3FF0000000000000, 3'b000);
        send_dir(0, 0, 0, 13'd127,  58'd3 << 55,                   0, 0, 0, 64'h000000003FC00000, 3'b000);
        send_dir(0, 0, 0, 13'd127,  58'd1 << 57,                   0, 0, 0, 64'h0000000040000000, 3'b000);
        send_dir(1, 0, 0, 13'd1023, (58'd1 << 56) | 58'h08,        0, 0, 0, 64'h3FF0000000000000, 3'b001);
        send_dir(1, 0, 0, 13'd1023, (58'd1 << 56) | 58'h18,        0, 0, 0, 64'h3FF0000000000002, 3'b001);
        send_dir(1, 1, 0, 13'd1023, (58'd1 << 56) | 58'h18,        0, 0, 0, 64'h3FF0000000000001, 3'b001);
        send_dir(1, 0, 0, 13'd2047, 58'd1 << 56,                   0, 0, 0, 64'h7FF0000000000000, 3'b101);
        send_dir(1, 1, 0, 13'd2047, 58'd1 << 56,                   0, 0, 0, 64'h7FEFFFFFFFFFFFFF, 3'b101);
        send_dir(0, 0, 0, 13'd0,    58'd1 << 56,                   0, 0, 0, 64'h0000000000400000, 3'b000);
        send_dir(0, 0, 0, 13'd0,    (58'd1 << 56) | 58'd1,         0, 0, 0, 64'h0000000000400000, 3'b011);
        send_dir(1, 0, 0, 13'd5,    58'd1 << 56,                   1, 1, 1, 64'h7FF8000000000000, 3'b000);
        send_dir(0, 0, 1, 13'd5,    58'd1 << 56,                   1, 1, 0, 64'h00000000FF800000, 3'b000);
        send_dir(1, 0, 1, 13'd900,  58'd1 << 50,                   1, 0, 0, 64'h8000000000000000, 3'b000);

        // Backpressure: only three items fit while the consumer stalls.
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            if (n_acc < 5) rand_drive();
            else           bus.in_valid = 1'b0;
            tick();
            if (acc_last) n_acc++;
        end
        #1;
        check("bp_accepted", 64'(n_acc), 64'd3);
        check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && !(n_acc == 5 && sb_q.size() == 0); c++) begin
            if (n_acc < 5) rand_drive();
            else           bus.in_valid = 1'b0;
            tick();
            if (acc_last) n_acc++;
        end
        check("bp_total", 64'(n_acc), 64'd5);
        check("bp_drain", 64'(sb_q.size()), 64'd0);

        // Reset with the pipe full must drop everything immediately.
        repeat (4) begin
            rand_drive();
            tick();
        end
        #1;
        check("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_fp_out", bus.fp_out, 64'd0);
        sb_q.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post_rst_quiet", {63'd0, bus.out_valid}, 64'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 7) rand_drive();
            else                          bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
        check("final_drain", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_encoder.md
Name: fp_encoder

Overview:
- Pipelined packer: the inverse direction of the team's FP decode path.
- Takes an unpacked internal result (sign, wide biased exponent, extended mantissa, special-value flags) from the FPU datapath, then normalizes, rounds and packs it into IEEE-754 FP64 or FP32.
- Raises overflow, underflow and inexact flags.
- Sits at the FPU writeback boundary, behind a valid/ready handshake.

Parameters:
- EXP_W, 13, width of signed biased exponent input (two's complement).
- MANT_W, 58, extended mantissa width: 2 integer bits, 52 fraction bits, 4 extra round bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input item valid
- in_ready  out  1  encoder can accept an item this cycle
- is_double_precision  in  1  1 = FP64 result, 0 = FP32 result
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; others treated as RNE
- sign_in  in  1  result sign
- exp_in  in  EXP_W  signed biased exponent (FP32 bias 127, FP64 bias 1023)
- mant_in  in  MANT_W  value = mant_in / 2^56
- is_zero_in  in  1  force signed zero
- is_inf_in  in  1  force signed infinity
- is_nan_in  in  1  force canonical NaN
- out_valid  out  1  fp_out valid
- out_ready  in  1  consumer accepts
- fp_out  out  64  packed result; FP32 results occupy [31:0] with [63:32] = 0
- flag_overflow  out  1  overflow
- flag_underflow  out  1  underflow
- flag_inexact  out  1  inexact

Behaviour:
- Reset: all stage valids, out_valid, fp_out and flags go to 0 immediately. Reset mid-operation discards all in-flight items. in_ready = 1 after reset.
- Pipeline: 3 stages (S1 normalize, S2 round, S3 pack). Latency is 3 cycles from an accepted input to out_valid when unstalled. Throughput is 1 item per cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance.
  - All stages shift together on advance; bubbles are not collapsed.
  - An input transfers when in_valid && in_ready.
  - fp_out and flags hold stable while out_valid && !out_ready.
- Per-item state: precision and rm travel with each item. Mixed precision back-to-back is legal.
- Special precedence: nan > inf > zero. Specials bypass arithmetic and raise no flags.
  - NaN: FP64 0x7FF8000000000000, FP32 0x7FC00000.
  - Inf: sign, exp all-ones, fraction 0.
  - Zero, or mant_in == 0: signed zero.
- S1 normalize:
  - If mant_in[57] is set: shift right 1, exp+1; shifted-out bit ORs into sticky.
  - Otherwise: left-shift by the leading-zero count until bit 56 is set, exp -= shift.
  - If the exponent would fall below 1: right-shift by (1 - exp) with sticky accumulation and set exp = 0 (denormal). Right-shift is saturated at MANT_W.
  - Tininess is flagged before rounding: exp < 1 prior to the denormal shift.
- S2 round:
  - LSB position: FP64 bit 4, FP32 bit 33.
  - guard = bit just below the LSB; sticky = OR of all lower bits.
  - inexact = guard | sticky.
  - Increment rules:
    - RNE: guard && (sticky || lsb)
    - RTZ: never
    - RDN: sign && inexact
    - RUP: !sign && inexact
    - RMM: guard
  - Carry into bit 57 renormalizes: shift right 1, exp+1.
  - A denormal rounding up into bit 56 gets exp = 1.
- S3 pack:
  - EMAX is 2047 (FP64) or 255 (FP32). Overflow when exp >= EMAX; sets overflow and inexact.
  - Overflowed result is inf for RNE/RMM, for RUP when sign is +, and for RDN when sign is −. Otherwise it is max finite (FP64 0x7FEFFFFFFFFFFFFF, FP32 0x7F7FFFFF, with sign applied).
  - underflow = tiny && inexact.
  - Fraction is taken from the rounded mantissa (52 or 23 bits below bit 56).

Decomposition:
- Shared package fpu_pkg holds:
  - rounding-mode enum `rm_e`
  - bias/EMAX constants and FP32/FP64 canonical NaN constants
  - stage payload struct (sign, exp, mant, precision, rm, special, tiny, sticky)
- One sub-module, fp_lzc: parameterized leading-zero counter used by S1.

Test Plan:
- FP64 1.0: exp_in=1023, mant_in=1<<56, RNE → fp_out=0x3FF0000000000000 exactly 3 cycles after accept, no flags.
- FP32 1.5: exp_in=127, mant_in=3<<55, precision=0 → 0x3FC00000. Also exp_in=127, mant_in=1<<57 → 0x40000000 (right-normalize).
- RNE ties, FP64, exp 1023, guard=1, sticky=0:
  - LSB=0 → fraction unchanged, inexact=1.
  - LSB=1 → fraction+1.
  - Same LSB=1 input with RTZ → unchanged.
- Overflow FP64: exp_in=2047, mant_in=1<<56.
  - RNE → 0x7FF0000000000000, overflow=1, inexact=1.
  - RTZ → 0x7FEFFFFFFFFFFFFF.
- Denormal FP32: exp_in=0, mant_in=1<<56 → 0x00400000, underflow=0 (exact). Add sticky bit 0 → underflow=1, inexact=1.
- Backpressure/reset:
  - Issue 5 items with out_ready=0 → in_ready drops after 3 accepted; release → outputs in order, none lost.
  - Assert rst mid-stream → out_valid=0 the same cycle, no stale output afterwards.
- Specials: is_nan_in with precision=1 → 0x7FF8000000000000; is_inf_in with sign=1, precision=0 → 0xFF800000; no flags.
